// File: rtl/p405s_srm_pkg.sv
// Shared definitions for the SRM rotate-and-mask datapath: mode encodings and
// the big-endian mask generator used by the decode stage.
package p405s_srm_pkg;

  localparam logic SRM_MODE_AND = 1'b0;
  localparam logic SRM_MODE_INS = 1'b1;
  localparam int   SRM_MAX_W    = 64;

  // Bit i of the big-endian mask lives in vector bit (width-1-i); result sits in the low width bits.
  function automatic logic [SRM_MAX_W-1:0] mask_gen(input int width, input int mb, input int me,
                                                    input logic force_zero);
    logic [SRM_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < SRM_MAX_W; i++) begin
      if ((i < width) && !force_zero) begin
        if (mb <= me) begin
          m[width-1-i] = (i >= mb) && (i <= me);
        end else begin
          m[width-1-i] = (i <= me) || (i >= mb);
        end
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/p405s_srm_mask_pipe_if.sv
// Request/response bundle of the SRM mask pipe; slave is the unit, master the
// operand-read / writeback side.
interface p405s_srm_mask_pipe_if #(
  parameter int WIDTH = 32
) ();
  localparam int FLD = $clog2(WIDTH);

  logic             inValid;
  logic             inReady;
  logic             insertMode;
  logic             forceZero;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] raData;
  logic [FLD-1:0]   shAmt;
  logic [FLD-1:0]   mbField;
  logic [FLD-1:0]   meField;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic             outWrap;

  modport master (
    output inValid, insertMode, forceZero, rsData, raData, shAmt, mbField, meField, outReady,
    input  inReady, outValid, outData, outWrap
  );

  modport slave (
    input  inValid, insertMode, forceZero, rsData, raData, shAmt, mbField, meField, outReady,
    output inReady, outValid, outData, outWrap
  );
endinterface

// File: rtl/p405s_srm_mask_cmp.sv
// me < mb detector: carry-out of me + ~mb + 1 built as a flat generate/propagate
// look-ahead; no carry means me < mb, i.e. the mask wraps.
module p405s_srm_mask_cmp #(
  parameter int FLD = 5
) (
  input  logic [FLD-1:0] me,
  input  logic [FLD-1:0] mb,
  output logic           wrap
);

  logic [FLD-1:0] g_s;
  logic [FLD-1:0] p_s;
  logic           carry_s;
  logic           term_s;

  // Each bit's generate survives only through all higher propagates; the carry-in needs every propagate.
  always_comb begin
    g_s     = me & ~mb;
    p_s     = me | ~mb;
    carry_s = &p_s;
    term_s  = 1'b0;
    for (int i = 0; i < FLD; i++) begin
      term_s = g_s[i];
      for (int j = i + 1; j < FLD; j++) begin
        term_s = term_s & p_s[j];
      end
      carry_s = carry_s | term_s;
    end
    wrap = ~carry_s;
  end

endmodule

// File: rtl/p405s_srm_mask_pipe.sv
// Two-stage rotate-and-mask unit: stage A registers rotated operand, mask and
// insert target; stage B registers the AND or insert result.
module p405s_srm_mask_pipe
  import p405s_srm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  CB,
  input  logic                  resetL,
  input  logic                  flush,
  p405s_srm_mask_pipe_if.slave  bus
);

  localparam int FLD = $clog2(WIDTH);

  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] a_rot_q, a_rot_d;
  logic [WIDTH-1:0] a_mask_q, a_mask_d;
  logic [WIDTH-1:0] a_ra_q, a_ra_d;
  logic             a_ins_q, a_ins_d;
  logic             a_wrap_q, a_wrap_d;
  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic             b_wrap_q, b_wrap_d;

  logic               a_adv_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               wrap_s;
  logic [2*WIDTH-1:0] rot_dbl_s;

  p405s_srm_mask_cmp #(.FLD(FLD)) u_cmp (
    .me   (bus.meField),
    .mb   (bus.mbField),
    .wrap (wrap_s)
  );

  assign a_adv_s    = a_valid_q & (~b_valid_q | bus.outReady);
  assign in_ready_s = ~a_valid_q | a_adv_s;
  assign accept_s   = bus.inValid & in_ready_s & ~flush;

  assign bus.inReady  = in_ready_s;
  assign bus.outValid = b_valid_q;
  assign bus.outData  = b_data_q;
  assign bus.outWrap  = b_wrap_q;

  // Stage A next state: rotate, mask decode and capture on accept.
  always_comb begin
    rot_dbl_s = {bus.rsData, bus.rsData} << bus.shAmt;
    a_valid_d = a_valid_q;
    a_rot_d   = a_rot_q;
    a_mask_d  = a_mask_q;
    a_ra_d    = a_ra_q;
    a_ins_d   = a_ins_q;
    a_wrap_d  = a_wrap_q;
    if (flush) begin
      a_valid_d = 1'b0;
    end else if (accept_s) begin
      a_valid_d = 1'b1;
      a_rot_d   = rot_dbl_s[2*WIDTH-1:WIDTH];
      a_mask_d  = WIDTH'(mask_gen(WIDTH, int'(bus.mbField), int'(bus.meField), bus.forceZero));
      a_ra_d    = bus.raData;
      a_ins_d   = bus.insertMode;
      a_wrap_d  = bus.forceZero ? 1'b0 : wrap_s;
    end else if (a_adv_s) begin
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end
  end

  // Stage B next state: combine under the mask when stage A advances.
  always_comb begin
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_wrap_d  = b_wrap_q;
    if (flush) begin
      b_valid_d = 1'b0;
    end else if (a_adv_s) begin
      b_valid_d = 1'b1;
      b_wrap_d  = a_wrap_q;
      if (a_ins_q == SRM_MODE_INS) begin
        b_data_d = (a_rot_q & a_mask_q) | (a_ra_q & ~a_mask_q);
      end else begin
        b_data_d = a_rot_q & a_mask_q;
      end
    end else if (bus.outReady) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      a_valid_q <= 1'b0;
      a_rot_q   <= '0;
      a_mask_q  <= '0;
      a_ra_q    <= '0;
      a_ins_q   <= 1'b0;
      a_wrap_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_wrap_q  <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_rot_q   <= a_rot_d;
      a_mask_q  <= a_mask_d;
      a_ra_q    <= a_ra_d;
      a_ins_q   <= a_ins_d;
      a_wrap_q  <= a_wrap_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_wrap_q  <= b_wrap_d;
    end
  end

endmodule

// File: tb/tb_p405s_srm_mask_pipe.sv
// Scoreboard bench for p405s_srm_mask_pipe: 32-bit random traffic against an
// arithmetic reference model, plus directed 64-bit, flush and reset cases.
module tb_p405s_srm_mask_pipe;

  logic CB = 1'b0;
  logic resetL;
  logic flush;

  always #5 CB = ~CB;

  p405s_srm_mask_pipe_if #(.WIDTH(32)) if32 ();
  p405s_srm_mask_pipe_if #(.WIDTH(64)) if64 ();

  p405s_srm_mask_pipe #(.WIDTH(32)) u_dut32 (.CB(CB), .resetL(resetL), .flush(flush), .bus(if32));
  p405s_srm_mask_pipe #(.WIDTH(64)) u_dut64 (.CB(CB), .resetL(resetL), .flush(flush), .bus(if64));

  int n_chk  = 0;
  int n_pass = 0;
  logic [32:0] q32[$];
  logic [64:0] q64[$];
  bit   rnd_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: rotate via a right shift of the doubled word, mask from shifted all-ones runs.
  function automatic logic [32:0] model32(input logic [31:0] rs, input logic [31:0] ra, input int sh,
                                          input int mb, input int me, input logic ins, input logic fz);
    logic [63:0] dbl;
    logic [31:0] rot, ones, m;
    dbl  = {rs, rs} >> (32 - sh);
    rot  = dbl[31:0];
    ones = 32'hFFFF_FFFF;
    if (fz) m = 32'h0;
    else if (mb <= me) m = (ones >> mb) & ~((ones >> me) >> 1);
    else m = ~((ones >> (me + 1)) & ~(ones >> mb));
    return {(!fz && (me < mb)), ins ? ((rot & m) | (ra & ~m)) : (rot & m)};
  endfunction

  task automatic send32(input logic [31:0] rs, input logic [31:0] ra, input logic [4:0] sh,
                        input logic [4:0] mb, input logic [4:0] me, input logic ins,
                        input logic fz, input logic [32:0] exp);
    bit done = 1'b0;
    if32.inValid = 1'b1; if32.rsData = rs; if32.raData = ra; if32.shAmt = sh;
    if32.mbField = mb; if32.meField = me; if32.insertMode = ins; if32.forceZero = fz;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CB);
      if (if32.inReady && !flush) begin
        q32.push_back(exp);
        done = 1'b1;
      end
      @(posedge CB); #1;
    end
    if32.inValid = 1'b0;
    check("send32_accept", 64'(done), 64'd1);
  endtask

  task automatic rand_send32();
    logic [31:0] rs, ra;
    logic [4:0]  sh, mb, me;
    logic        ins, fz;
    rs = $urandom; ra = $urandom;
    sh = 5'($urandom_range(0, 31)); mb = 5'($urandom_range(0, 31)); me = 5'($urandom_range(0, 31));
    ins = 1'($urandom_range(0, 1)); fz = ($urandom_range(0, 7) == 0);
    send32(rs, ra, sh, mb, me, ins, fz, model32(rs, ra, int'(sh), int'(mb), int'(me), ins, fz));
  endtask

  task automatic send64(input logic [63:0] rs, input logic [63:0] ra, input logic [5:0] sh,
                        input logic [5:0] mb, input logic [5:0] me, input logic ins,
                        input logic fz, input logic [64:0] exp);
    bit done = 1'b0;
    if64.inValid = 1'b1; if64.rsData = rs; if64.raData = ra; if64.shAmt = sh;
    if64.mbField = mb; if64.meField = me; if64.insertMode = ins; if64.forceZero = fz;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CB);
      if (if64.inReady && !flush) begin
        q64.push_back(exp);
        done = 1'b1;
      end
      @(posedge CB); #1;
    end
    if64.inValid = 1'b0;
    check("send64_accept", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (q32.size() != 0 || q64.size() != 0); c++) @(posedge CB);
    check("drain_empty", 64'(q32.size() + q64.size()), 64'd0);
    @(posedge CB); #1;
  endtask

  // Random consumer back-pressure while enabled.
  always @(posedge CB) begin
    #1;
    if (rnd_bp) if32.outReady = ($urandom_range(0, 3) != 0);
  end

  logic [31:0] prev_d32;
  logic        prev_w32;
  bit          prev_stall32 = 1'b0;

  // 32-bit monitor: pop and compare on each transfer, and check hold-stable while stalled.
  always @(negedge CB) begin
    logic [32:0] e;
    if (!resetL) begin
      prev_stall32 = 1'b0;
    end else if (flush) begin
      q32.delete();
      prev_stall32 = 1'b0;
    end else begin
      if (prev_stall32) begin
        check("stall_valid", 64'(if32.outValid), 64'd1);
        check("stall_data", 64'(if32.outData), 64'(prev_d32));
        check("stall_wrap", 64'(if32.outWrap), 64'(prev_w32));
      end
      if (if32.outValid && if32.outReady) begin
        if (q32.size() == 0) begin
          check("spurious32", 64'(if32.outValid), 64'd0);
        end else begin
          e = q32.pop_front();
          check("data32", 64'(if32.outData), 64'(e[31:0]));
          check("wrap32", 64'(if32.outWrap), 64'(e[32]));
        end
      end
      prev_stall32 = if32.outValid && !if32.outReady;
      prev_d32     = if32.outData;
      prev_w32     = if32.outWrap;
    end
  end

  // 64-bit monitor.
  always @(negedge CB) begin
    logic [64:0] e;
    if (!resetL) begin
      e = '0;
    end else if (flush) begin
      q64.delete();
    end else if (if64.outValid && if64.outReady) begin
      if (q64.size() == 0) begin
        check("spurious64", 64'(if64.outValid), 64'd0);
      end else begin
        e = q64.pop_front();
        check("data64", if64.outData, e[63:0]);
        check("wrap64", 64'(if64.outWrap), 64'(e[64]));
      end
    end
  end

  initial begin
    logic [31:0] rs, ra;
    resetL = 1'b0;
    flush  = 1'b0;
    {if32.inValid, if32.insertMode, if32.forceZero, if32.rsData, if32.raData} = '0;
    {if32.shAmt, if32.mbField, if32.meField} = '0;
    if32.outReady = 1'b1;
    {if64.inValid, if64.insertMode, if64.forceZero, if64.rsData, if64.raData} = '0;
    {if64.shAmt, if64.mbField, if64.meField} = '0;
    if64.outReady = 1'b1;

    @(posedge CB); #1;
    check("rst_valid", 64'(if32.outValid), 64'd0);
    check("rst_data", 64'(if32.outData), 64'd0);
    check("rst_wrap", 64'(if32.outWrap), 64'd0);
    check("rst_ready", 64'(if32.inReady), 64'd1);
    @(posedge CB); #1;
    resetL = 1'b1;

    // Directed cases with a free-running consumer.
    send32(32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, {1'b0, 32'hDEADBEEF});
    check("lat_edge1", 64'(if32.outValid), 64'd0);
    @(posedge CB); #1;
    check("lat_edge2", 64'(if32.outValid), 64'd1);
    send32(32'hFFFFFFFF, 32'h0, 5'd0, 5'd28, 5'd3, 1'b0, 1'b0, {1'b1, 32'hF000000F});
    send32(32'hFFFFFFFF, 32'h0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, {1'b0, 32'h04000000});
    send32(32'h000000AB, 32'h12345678, 5'd8, 5'd16, 5'd23, 1'b1, 1'b0, {1'b0, 32'h1234AB78});
    send32(32'hCAFEF00D, 32'h12345678, 5'd3, 5'd20, 5'd3, 1'b1, 1'b1, {1'b0, 32'h12345678});
    send32(32'hCAFEF00D, 32'h12345678, 5'd3, 5'd20, 5'd3, 1'b0, 1'b1, {1'b0, 32'h00000000});
    drain();

    // Back-pressure: two accepted then inReady drops; stall three more cycles.
    if32.outReady = 1'b0;
    rand_send32();
    rand_send32();
    check("bp_ready_low", 64'(if32.inReady), 64'd0);
    fork
      begin rand_send32(); rand_send32(); end
      begin repeat (3) @(posedge CB); #1; if32.outReady = 1'b1; end
    join
    drain();

    // Flush with two buffered results and a same-cycle request that must be dropped.
    if32.outReady = 1'b0;
    rand_send32();
    rand_send32();
    flush = 1'b1;
    if32.inValid = 1'b1; rs = $urandom; if32.rsData = rs;
    @(posedge CB); #1;
    flush = 1'b0;
    if32.inValid = 1'b0;
    check("flush_valid", 64'(if32.outValid), 64'd0);
    check("flush_ready", 64'(if32.inReady), 64'd1);
    if32.outReady = 1'b1;
    repeat (5) @(posedge CB); #1;

    // Randomized traffic with random back-pressure and occasional flushes.
    rnd_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge CB); #1; end
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        @(posedge CB); #1;
        flush = 1'b0;
      end
      rand_send32();
    end
    rnd_bp = 1'b0;
    if32.outReady = 1'b1;
    drain();

    // 64-bit build.
    send64(64'h0123456789ABCDEF, 64'h0, 6'd4, 6'd60, 6'd3, 1'b0, 1'b0, {1'b1, 64'h1000000000000000});
    send64(64'h0123456789ABCDEF, 64'h0, 6'd60, 6'd0, 6'd63, 1'b0, 1'b0, {1'b0, 64'hF0123456789ABCDE});
    send64(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 6'd9, 6'd40, 6'd7, 1'b1, 1'b1,
           {1'b0, 64'hFEDCBA9876543210});
    drain();

    // Reset in the middle of buffered traffic.
    if32.outReady = 1'b0;
    if64.outReady = 1'b0;
    rand_send32();
    send64(64'h1, 64'h0, 6'd1, 6'd0, 6'd63, 1'b0, 1'b0, {1'b0, 64'h2});
    rand_send32();
    @(posedge CB); #3;
    resetL = 1'b0;
    #1;
    check("mid_rst_valid32", 64'(if32.outValid), 64'd0);
    check("mid_rst_data32", 64'(if32.outData), 64'd0);
    check("mid_rst_wrap32", 64'(if32.outWrap), 64'd0);
    check("mid_rst_ready32", 64'(if32.inReady), 64'd1);
    check("mid_rst_valid64", 64'(if64.outValid), 64'd0);
    check("mid_rst_data64", if64.outData, 64'd0);
    q32.delete();
    q64.delete();
    @(posedge CB); #1;
    resetL = 1'b1;
    if32.outReady = 1'b1;
    if64.outReady = 1'b1;
    send32(32'hDEADBEEF, 32'h0, 5'd4, 5'd0, 5'd31, 1'b0, 1'b0, {1'b0, 32'hEADBEEFD});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
